mem_requester: RTL

MEM_REQUESTER -- requirements
Module: mem_requester

---
 rtl/mem_requester_if.sv | 29 ++
 rtl/mem_requester.sv | 136 +++++++++++++
 2 files changed

// File: rtl/mem_requester_if.sv
// Memory-stage handshake bundle: pipeline request side plus data-memory strobe/ack side.
// master is the requester's view; slave is the surrounding pipeline/memory view.
interface mem_requester_if;
  logic        start;
  logic [3:0]  icode;
  logic [63:0] ValA;
  logic [63:0] ValE;
  logic [63:0] ValP;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic [63:0] ValM;
  logic        busy;
  logic        done;
  logic        adr_error;

  modport master (
    input  start, icode, ValA, ValE, ValP, mem_ack, mem_rdata,
    output mem_addr, mem_wdata, mem_rd, mem_wr, ValM, busy, done, adr_error
  );

  modport slave (
    output start, icode, ValA, ValE, ValP, mem_ack, mem_rdata,
    input  mem_addr, mem_wdata, mem_rd, mem_wr, ValM, busy, done, adr_error
  );
endinterface

// File: rtl/mem_requester.sv
// Y86 memory-stage requester: decodes icode into one data-memory access,
// waits for ack with a bounded timeout and reports completion/address errors.
module mem_requester #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic            clk,
  input  logic            reset,
  mem_requester_if.master bus
);
  localparam int unsigned     CNT_W    = (TIMEOUT > 15) ? $clog2(TIMEOUT + 1) : 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t             r_state, w_state;
  logic [CNT_W-1:0]   r_cnt, w_cnt;
  logic [63:0]        r_addr, w_addr;
  logic [63:0]        r_wdata, w_wdata;
  logic [63:0]        r_valm, w_valm;
  logic               r_rd, w_rd;
  logic               r_wr, w_wr;
  logic               r_busy, w_busy;
  logic               r_done, w_done;
  logic               r_err, w_err;

  logic [63:0]        w_dec_addr;
  logic [63:0]        w_dec_data;
  logic               w_dec_rd;
  logic               w_dec_wr;
  logic               w_dec_bad;

  // Instruction decode: address, write data and direction of the access.
  always_comb begin
    w_dec_addr = '0;
    w_dec_data = '0;
    w_dec_rd   = 1'b0;
    w_dec_wr   = 1'b0;
    case (bus.icode)
      4'h4: begin w_dec_addr = bus.ValE; w_dec_data = bus.ValA; w_dec_wr = 1'b1; end
      4'h5: begin w_dec_addr = bus.ValE; w_dec_rd = 1'b1; end
      4'h8: begin w_dec_addr = bus.ValE; w_dec_data = bus.ValP; w_dec_wr = 1'b1; end
      4'h9: begin w_dec_addr = bus.ValA; w_dec_rd = 1'b1; end
      4'hA: begin w_dec_addr = bus.ValE; w_dec_data = bus.ValA; w_dec_wr = 1'b1; end
      4'hB: begin w_dec_addr = bus.ValA; w_dec_rd = 1'b1; end
      default: ;
    endcase
    w_dec_bad = (w_dec_addr >= 64'(MEM_WORDS));
  end

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_valm  = r_valm;
    w_rd    = r_rd;
    w_wr    = r_wr;
    w_err   = r_err;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_err   = 1'b0;
          w_addr  = w_dec_addr;
          w_wdata = w_dec_data;
          w_cnt   = '0;
          if (!(w_dec_rd || w_dec_wr)) begin
            w_state = S_RESP;
          end else if (w_dec_bad) begin
            w_state = S_RESP;
            w_err   = 1'b1;
          end else begin
            w_state = S_ACCESS;
            w_rd    = w_dec_rd;
            w_wr    = w_dec_wr;
          end
        end
      end
      S_ACCESS: begin
        if (bus.mem_ack) begin
          w_state = S_RESP;
          w_rd    = 1'b0;
          w_wr    = 1'b0;
          if (r_rd) w_valm = bus.mem_rdata;
        end else if (r_cnt == CNT_LAST) begin
          w_state = S_RESP;
          w_rd    = 1'b0;
          w_wr    = 1'b0;
          w_err   = 1'b1;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_RESP:  w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
    w_done = (w_state == S_RESP);
    w_busy = (w_state != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_valm  <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_valm  <= w_valm;
      r_rd    <= w_rd;
      r_wr    <= w_wr;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_err   <= w_err;
    end
  end

  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_rd    = r_rd;
  assign bus.mem_wr    = r_wr;
  assign bus.ValM      = r_valm;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.adr_error = r_err;
endmodule
